// File: rtl/apb_sram_ctrl_pkg.sv
// Shared types, default sizes and address check for the APB-to-SRAM front-end.
// Used by apb_sram_ctrl_if and apb_sram_ctrl.
package apb_sram_pkg;

    localparam int DATAWIDTH = 32;
    localparam int ADDRWIDTH = 32;
    localparam int RAM_DEPTH = 128;

    typedef enum logic [2:0] {
        IDLE,
        W_ACC,
        R_REQ,
        R_DONE,
        ERR
    } state_t;

    // True when a byte address is word aligned and falls inside a depth-word SRAM.
    function automatic logic addr_ok(input logic [63:0] paddr, input int unsigned depth);
        return (paddr < (64'(depth) * 64'd4)) && (paddr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/apb_sram_ctrl_if.sv
// APB3 bus bundle between the interconnect (master) and apb_sram_ctrl (slave).
interface apb_sram_ctrl_if #(
    parameter int DATAWIDTH = apb_sram_pkg::DATAWIDTH,
    parameter int ADDRWIDTH = apb_sram_pkg::ADDRWIDTH
) ();
    import apb_sram_pkg::*;

    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDRWIDTH-1:0] paddr;
    logic [DATAWIDTH-1:0] pwdata;
    logic [DATAWIDTH-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_sram_ctrl.sv
// APB3 slave driving a single-port SRAM: zero-wait writes, one-wait reads.
// Optional slave-error checking of out-of-range / misaligned addresses under APB_SLVERR_EN.
module apb_sram_ctrl #(
    parameter int  DATAWIDTH = apb_sram_pkg::DATAWIDTH,
    parameter int  ADDRWIDTH = apb_sram_pkg::ADDRWIDTH,
    parameter int  RAM_DEPTH = apb_sram_pkg::RAM_DEPTH,
    localparam int RAM_AW    = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    apb_sram_ctrl_if.slave       bus,
    output logic                 ram_sel,
    output logic                 ram_we,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic [DATAWIDTH-1:0] ram_wdata,
    input  logic [DATAWIDTH-1:0] ram_rdata
);
    import apb_sram_pkg::*;

    state_t            state_q;
    state_t            state_d;
    logic              setup;
    logic              addr_err;
    logic              sel_d;
    logic              we_d;
    logic [RAM_AW-1:0] word_idx;

    assign setup    = bus.psel & ~bus.penable;
    assign word_idx = bus.paddr[RAM_AW+1:2];

`ifdef APB_SLVERR_EN
    logic err_q;

    assign addr_err    = ~addr_ok(64'(bus.paddr), RAM_DEPTH);
    assign bus.pslverr = (state_q == ERR) & err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && setup) begin
            err_q <= addr_err;
        end
    end
`else
    // Upper and byte-lane address bits are deliberately dropped: addresses alias.
    logic unused_paddr;

    assign unused_paddr = ^{bus.paddr[ADDRWIDTH-1:RAM_AW+2], bus.paddr[1:0]};
    assign addr_err     = 1'b0;
    assign bus.pslverr  = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        sel_d   = 1'b0;
        we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    if (addr_err) begin
                        state_d = ERR;
                    end else begin
                        sel_d   = 1'b1;
                        we_d    = bus.pwrite;
                        state_d = bus.pwrite ? W_ACC : R_REQ;
                    end
                end
            end
            // A master dropping psel mid-read abandons it; the data phase is skipped.
            R_REQ:   state_d = bus.psel ? R_DONE : IDLE;
            W_ACC:   state_d = IDLE;
            R_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ram_sel   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state_q <= state_d;
            ram_sel <= sel_d;
            ram_we  <= we_d;
            if (state_q == IDLE && setup) begin
                ram_addr  <= word_idx;
                ram_wdata <= bus.pwdata;
            end
        end
    end

    // Response is decoded from state; read data passes straight through from the SRAM.
    assign bus.pready = (state_q == W_ACC) || (state_q == R_DONE) || (state_q == ERR);
    assign bus.prdata = (state_q == R_DONE) ? ram_rdata : '0;

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Self-checking bench for apb_sram_ctrl: directed cases plus random APB traffic
// compared against a word-array reference model. Honours APB_SLVERR_EN when defined.
`timescale 1ns/1ps
module tb_apb_sram_ctrl;

    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int DEPTH  = 128;
    localparam int RAM_AW = $clog2(DEPTH);
`ifdef APB_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_sram_ctrl_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

    logic              ram_sel;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;

    apb_sram_ctrl #(
        .DATAWIDTH(DW),
        .ADDRWIDTH(AW),
        .RAM_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .ram_sel   (ram_sel),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // SRAM macro: writes commit on the edge, read data registered one cycle later.
    logic [DW-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (ram_sel && ram_we)  sram[ram_addr] <= ram_wdata;
        if (ram_sel && !ram_we) ram_rdata      <= sram[ram_addr];
    end

    // Reference model: plain word array indexed by byte address / 4, wrapped to depth.
    logic [DW-1:0] ref_mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ram_sel must never stay high on two consecutive edges.
    logic sel_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) check("sel_single_cycle", {63'b0, ram_sel & sel_prev}, 64'd0);
        sel_prev <= ram_sel;
    end

    task automatic idle(input int n);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One APB transfer starting at #1 after an edge; expectations come from ref_mem.
    task automatic do_xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        int unsigned   idx;
        bit            exp_err;
        int            exp_lat;
        logic [DW-1:0] exp_rdata;
        int            lat;
        logic          sel_seen;

        idx       = (addr / 4) % DEPTH;
        exp_err   = SLVERR_EN && ((addr >= DEPTH * 4) || (addr % 4 != 0));
        exp_lat   = (exp_err || wr) ? 1 : 2;
        exp_rdata = (!wr && !exp_err) ? ref_mem[idx] : '0;

        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        check({tag, "_setup_pready"}, bus.pready, 0);

        @(posedge clk); #1;
        bus.penable = 1'b1;
        lat         = 1;
        sel_seen    = ram_sel;
        if (!exp_err) begin
            check({tag, "_t1_sel"}, ram_sel, 1);
            check({tag, "_t1_we"}, ram_we, wr);
            check({tag, "_t1_addr"}, ram_addr, idx);
            if (wr) check({tag, "_t1_wdata"}, ram_wdata, wdata);
        end
        while (!bus.pready && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            sel_seen |= ram_sel;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_pslverr"}, bus.pslverr, exp_err);
        check({tag, "_prdata"}, bus.prdata, exp_rdata);
        if (exp_err) check({tag, "_no_sram_access"}, sel_seen, 0);

        if (wr && !exp_err) ref_mem[idx] = wdata;
        @(posedge clk); #1;
    endtask

    initial begin
        time t0;

        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", bus.pready, 0);
        check("rst_pslverr", bus.pslverr, 0);
        check("rst_prdata", bus.prdata, 0);
        check("rst_ram_sel", ram_sel, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        rst = 1'b0;
        idle(1);

        // Give every word a known value so later reads have a defined expectation.
        for (int i = 0; i < DEPTH; i++) begin
            do_xfer("fill", 1'b1, AW'(4 * i), $urandom);
        end
        idle(1);

        do_xfer("wr_10", 1'b1, 32'h10, 32'hDEAD_BEEF);
        idle(1);
        do_xfer("rd_10", 1'b0, 32'h10, '0);
        idle(2);

        // Back-to-back: setup phase directly follows each pready cycle.
        t0 = $time;
        do_xfer("b2b_wr0", 1'b1, 32'h0, 32'h1111_1111);
        do_xfer("b2b_rd0", 1'b0, 32'h0, '0);
        do_xfer("b2b_wr1fc", 1'b1, 32'h1FC, 32'hA5A5_A5A5);
        check("b2b_total_time", 64'($time - t0), 64'd70);
        do_xfer("b2b_rd1fc", 1'b0, 32'h1FC, '0);
        idle(1);

        // Reset asserted while the read sits in R_REQ.
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h10;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        check("rreq_sel", ram_sel, 1);
        check("rreq_pready", bus.pready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_pready", bus.pready, 0);
        check("midrst_ram_sel", ram_sel, 0);
        check("midrst_prdata", bus.prdata, 0);
        rst = 1'b0;
        idle(1);
        do_xfer("post_rst_rd", 1'b0, 32'h10, '0);
        idle(1);

        // Read abandoned in R_REQ: no response follows.
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h20;
        @(posedge clk); #1;
        idle(1);
        check("abort_rd_pready", bus.pready, 0);
        check("abort_rd_sel", ram_sel, 0);
        idle(1);
        check("abort_rd_pready2", bus.pready, 0);

        // Write abandoned in W_ACC still lands in the SRAM.
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h24;
        bus.pwdata  = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("abort_wr_sel", ram_sel, 1);
        idle(1);
        ref_mem[9] = 32'hCAFE_F00D;
        check("abort_wr_sel_drop", ram_sel, 0);
        do_xfer("abort_wr_rd", 1'b0, 32'h24, '0);
        idle(1);

`ifdef APB_SLVERR_EN
        do_xfer("err_rd_200", 1'b0, 32'h200, '0);
        idle(1);
        do_xfer("err_wr_13", 1'b1, 32'h13, 32'h1234_5678);
        idle(1);
        do_xfer("err_chk_10", 1'b0, 32'h10, '0);
`else
        do_xfer("alias_wr_204", 1'b1, 32'h204, 32'h5);
        idle(1);
        do_xfer("alias_rd_4", 1'b0, 32'h4, '0);
`endif
        idle(1);

        // Random traffic: mostly aligned in-range, some arbitrary and full-range addresses.
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] addr;
            int unsigned   kind;
            kind = $urandom % 8;
            if (kind < 6)       addr = AW'(4 * ($urandom % DEPTH));
            else if (kind == 6) addr = AW'($urandom % (DEPTH * 8));
            else                addr = $urandom;
            do_xfer("rand", 1'($urandom % 2), addr, $urandom);
            if ($urandom % 3 == 0) idle($urandom % 3);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
